// File: rtl/dht11_sensor_emu.sv
// dht11_sensor_emu: sensor end of the DHT11 single-wire bus.
// Waits for a long host low pulse, answers with the acknowledge, then
// sends a 40-bit frame (humidity, temperature, checksum) MSB first.
// All durations are parameters in microseconds and must be >= 1.
module dht11_sensor_emu #(
    parameter int unsigned CLKS_PER_US  = 50,
    parameter int unsigned START_MIN_US = 18000,
    parameter int unsigned RESP_DLY_US  = 30,
    parameter int unsigned ACK_US       = 80,
    parameter int unsigned BIT_LOW_US   = 50,
    parameter int unsigned ZERO_HI_US   = 27,
    parameter int unsigned ONE_HI_US    = 70
) (
    input  logic       i_Clock,
    input  logic       i_Rst_n,
    input  logic       i_En,
    input  logic [7:0] i_Hum_Int,
    input  logic [7:0] i_Hum_Float,
    input  logic [7:0] i_Temp_Int,
    input  logic [7:0] i_Temp_Float,
    input  logic       i_Crc_Corrupt,
    inout  wire        io_Dht_Data,
    output logic       o_Busy,
    output logic       o_Done,
    output logic [7:0] o_Frame_Cnt
);

    localparam int unsigned PreW = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StHostLow,
        StWaitRel,
        StAckLo,
        StAckHi,
        StBitLo,
        StBitHi,
        StEndLo
    } state_e;

    state_e          state_q, state_d;
    logic            sync_meta_q, sync_in_q, sync_prev_q;
    logic            fall;
    logic [PreW-1:0] pre_q;
    logic            us_tick;
    logic [31:0]     us_cnt_q;
    logic            state_chg;
    logic [39:0]     shift_q, shift_d;
    logic [5:0]      bit_idx_q, bit_idx_d;
    logic            done_q, done_d;
    logic [7:0]      frame_cnt_q;
    logic [7:0]      crc;
    logic [31:0]     hi_us;
    logic            drive_low;

    assign crc   = (i_Hum_Int + i_Hum_Float + i_Temp_Int + i_Temp_Float)
                   ^ {7'b0, i_Crc_Corrupt};
    assign fall  = sync_prev_q & ~sync_in_q;
    assign hi_us = shift_q[39] ? ONE_HI_US : ZERO_HI_US;

    assign us_tick   = (32'(pre_q) == CLKS_PER_US - 1);
    assign state_chg = (state_d != state_q);

    // Two-flop synchroniser plus a free-running edge detector; reset to the idle-high level
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            sync_meta_q <= 1'b1;
            sync_in_q   <= 1'b1;
            sync_prev_q <= 1'b1;
        end else begin
            sync_meta_q <= io_Dht_Data;
            sync_in_q   <= sync_meta_q;
            sync_prev_q <= sync_in_q;
        end
    end

    // Microsecond prescaler, restarted on every state change so each phase is exact
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            pre_q <= '0;
        end else if (state_chg || us_tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + 1'b1;
        end
    end

    // Elapsed microseconds in the current state, saturating
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            us_cnt_q <= '0;
        end else if (state_chg) begin
            us_cnt_q <= '0;
        end else if (us_tick && (us_cnt_q != 32'hFFFF_FFFF)) begin
            us_cnt_q <= us_cnt_q + 32'd1;
        end
    end

    // State, frame shift register, bit index, done pulse and frame counter
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            bit_idx_q   <= '0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            done_q    <= done_d;
            if (done_d) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    // Next-state logic: purely time-based once the start pulse is accepted
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (fall && i_En) begin
                    state_d = StHostLow;
                end
            end
            StHostLow: begin
                if (sync_in_q) begin
                    if (us_cnt_q >= START_MIN_US) begin
                        state_d = StWaitRel;
                        shift_d = {i_Hum_Int, i_Hum_Float, i_Temp_Int, i_Temp_Float, crc};
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StWaitRel: begin
                if (us_tick && (us_cnt_q >= RESP_DLY_US - 1)) begin
                    state_d = StAckLo;
                end
            end
            StAckLo: begin
                if (us_tick && (us_cnt_q >= ACK_US - 1)) begin
                    state_d = StAckHi;
                end
            end
            StAckHi: begin
                if (us_tick && (us_cnt_q >= ACK_US - 1)) begin
                    state_d   = StBitLo;
                    bit_idx_d = '0;
                end
            end
            StBitLo: begin
                if (us_tick && (us_cnt_q >= BIT_LOW_US - 1)) begin
                    state_d = StBitHi;
                end
            end
            StBitHi: begin
                if (us_tick && (us_cnt_q >= hi_us - 1)) begin
                    shift_d = {shift_q[38:0], 1'b0};
                    if (bit_idx_q == 6'd39) begin
                        state_d = StEndLo;
                    end else begin
                        state_d   = StBitLo;
                        bit_idx_d = bit_idx_q + 6'd1;
                    end
                end
            end
            StEndLo: begin
                if (us_tick && (us_cnt_q >= BIT_LOW_US - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Bus is open-drain: pulled low in the low phases, released otherwise
    always_comb begin
        drive_low = (state_q == StAckLo) || (state_q == StBitLo) || (state_q == StEndLo);
        o_Busy    = (state_q == StAckLo) || (state_q == StAckHi) || (state_q == StBitLo) ||
                    (state_q == StBitHi) || (state_q == StEndLo);
    end

    assign io_Dht_Data = drive_low ? 1'b0 : 1'bz;
    assign o_Done      = done_q;
    assign o_Frame_Cnt = frame_cnt_q;

endmodule

// File: tb/tb_dht11_sensor_emu.sv
// tb_dht11_sensor_emu: directed bench acting as the DHT11 host on a pulled-up bus.
module tb_dht11_sensor_emu;

    localparam int CLK_US = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       crc_bad;
    logic [7:0] hum_i, hum_f, tmp_i, tmp_f;
    logic       host_low;
    logic       busy, done;
    logic [7:0] frame_cnt;
    wire        dht;

    logic       host_low_s;
    logic       busy_s, done_s;
    logic [7:0] cnt_s;
    wire        dht_s;

    int n_total = 0;
    int n_bad   = 0;
    int done_cnt = 0;

    logic [39:0] rd_data;
    int          rd_ack_lo, rd_ack_hi, rd_bad_w;
    logic        rd_busy, rd_got;
    int          q_lows, q_busies, d0, rises, t, timeouts;
    logic        prev;

    always #5 clk = ~clk;

    pullup (dht);
    pullup (dht_s);
    assign dht   = host_low   ? 1'b0 : 1'bz;
    assign dht_s = host_low_s ? 1'b0 : 1'bz;

    dht11_sensor_emu #(
        .CLKS_PER_US  (CLK_US),
        .START_MIN_US (100)
    ) dut (
        .i_Clock       (clk),
        .i_Rst_n       (rst_n),
        .i_En          (en),
        .i_Hum_Int     (hum_i),
        .i_Hum_Float   (hum_f),
        .i_Temp_Int    (tmp_i),
        .i_Temp_Float  (tmp_f),
        .i_Crc_Corrupt (crc_bad),
        .io_Dht_Data   (dht),
        .o_Busy        (busy),
        .o_Done        (done),
        .o_Frame_Cnt   (frame_cnt)
    );

    // Tiny-timing instance so 256 frames fit in a short run
    dht11_sensor_emu #(
        .CLKS_PER_US  (1),
        .START_MIN_US (4),
        .RESP_DLY_US  (1),
        .ACK_US       (2),
        .BIT_LOW_US   (1),
        .ZERO_HI_US   (1),
        .ONE_HI_US    (2)
    ) dut_s (
        .i_Clock       (clk),
        .i_Rst_n       (rst_n),
        .i_En          (1'b1),
        .i_Hum_Int     (8'h00),
        .i_Hum_Float   (8'h00),
        .i_Temp_Int    (8'h00),
        .i_Temp_Float  (8'h00),
        .i_Crc_Corrupt (1'b0),
        .io_Dht_Data   (dht_s),
        .o_Busy        (busy_s),
        .o_Done        (done_s),
        .o_Frame_Cnt   (cnt_s)
    );

    // Count done pulses of the main instance
    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse width in microseconds, snapped to exp_us when inside [exp_us, exp_us+1]
    function automatic int win(input int cyc, input int exp_us);
        int us;
        us = cyc / CLK_US;
        return ((us >= exp_us) && (us <= exp_us + 1)) ? exp_us : us;
    endfunction

    task automatic count_level(input logic lvl, output int len);
        len = 0;
        while ((dht === lvl) && (len < 2000)) begin
            @(negedge clk);
            len++;
        end
    endtask

    task automatic host_pulse(input int us);
        host_low = 1'b1;
        repeat (us * CLK_US) @(negedge clk);
        host_low = 1'b0;
        @(negedge clk);
    endtask

    task automatic watch_quiet(input int cyc, output int lows, output int busies);
        lows = 0;
        busies = 0;
        repeat (cyc) begin
            @(negedge clk);
            if (dht !== 1'b1) lows++;
            if (busy !== 1'b0) busies++;
        end
    endtask

    task automatic read_frame(output logic [39:0] data, output int ack_lo, output int ack_hi,
                              output int bad_w, output logic busy_ack, output logic got);
        int n, h, w;
        data = '0; ack_lo = 0; ack_hi = 0; bad_w = 0; busy_ack = 1'b0; got = 1'b0;
        w = 0;
        while ((dht !== 1'b0) && (w < 400)) begin
            @(negedge clk);
            w++;
        end
        if (dht !== 1'b0) return;
        got = 1'b1;
        busy_ack = busy;
        count_level(1'b0, n);
        ack_lo = win(n, 80);
        count_level(1'b1, n);
        ack_hi = win(n, 80);
        for (int i = 0; i < 40; i++) begin
            count_level(1'b0, n);
            if (win(n, 50) != 50) bad_w++;
            count_level(1'b1, h);
            data = {data[38:0], ((h / CLK_US) > 48)};
            if ((win(h, 27) != 27) && (win(h, 70) != 70)) bad_w++;
        end
        count_level(1'b0, n);
        if (win(n, 50) != 50) bad_w++;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; crc_bad = 1'b0; host_low = 1'b0; host_low_s = 1'b0;
        hum_i = 8'd35; hum_f = 8'd0; tmp_i = 8'd24; tmp_f = 8'd0;
        repeat (4) @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_cnt", frame_cnt, 0);
        check_eq("rst_bus", dht, 1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: nominal frame 23 00 18 00 3B
        d0 = done_cnt;
        host_pulse(120);
        read_frame(rd_data, rd_ack_lo, rd_ack_hi, rd_bad_w, rd_busy, rd_got);
        check_eq("t1_got", rd_got, 1);
        check_eq("t1_ack_lo_us", rd_ack_lo, 80);
        check_eq("t1_ack_hi_us", rd_ack_hi, 80);
        check_eq("t1_busy_at_ack", rd_busy, 1);
        check_eq("t1_data", rd_data, 40'h23_00_18_00_3B);
        check_eq("t1_widths", rd_bad_w, 0);
        repeat (4) @(negedge clk);
        check_eq("t1_done_pulses", done_cnt - d0, 1);
        check_eq("t1_cnt", frame_cnt, 1);
        check_eq("t1_busy_after", busy, 0);

        // 2: short host pulse is not a start
        host_pulse(60);
        watch_quiet(400, q_lows, q_busies);
        check_eq("t2_bus_lows", q_lows, 0);
        check_eq("t2_busy", q_busies, 0);
        check_eq("t2_cnt", frame_cnt, 1);

        // 3: checksum corruption, all-ones payload
        hum_i = 8'hFF; hum_f = 8'hFF; tmp_i = 8'hFF; tmp_f = 8'hFF; crc_bad = 1'b1;
        host_pulse(120);
        read_frame(rd_data, rd_ack_lo, rd_ack_hi, rd_bad_w, rd_busy, rd_got);
        check_eq("t3_data", rd_data, 40'hFF_FF_FF_FF_FD);
        check_eq("t3_widths", rd_bad_w, 0);
        repeat (4) @(negedge clk);
        check_eq("t3_cnt", frame_cnt, 2);

        // 4: disabled start ignored; disable and input change mid-frame do not disturb it
        hum_i = 8'd35; hum_f = 8'd0; tmp_i = 8'd24; tmp_f = 8'd0; crc_bad = 1'b0;
        en = 1'b0;
        host_pulse(120);
        watch_quiet(400, q_lows, q_busies);
        check_eq("t4_off_lows", q_lows, 0);
        check_eq("t4_off_busy", q_busies, 0);
        en = 1'b1;
        host_pulse(120);
        fork
            read_frame(rd_data, rd_ack_lo, rd_ack_hi, rd_bad_w, rd_busy, rd_got);
            begin
                // lands inside bit 10
                repeat (2220) @(negedge clk);
                en = 1'b0;
                tmp_i = 8'h19;
            end
        join
        check_eq("t4_data", rd_data, 40'h23_00_18_00_3B);
        check_eq("t4_widths", rd_bad_w, 0);
        repeat (4) @(negedge clk);
        check_eq("t4_cnt", frame_cnt, 3);
        en = 1'b1;

        // 5: reset during the high phase of bit 20, then a clean frame with the new byte
        host_pulse(120);
        rises = 0; t = 0; prev = dht;
        while ((rises < 22) && (t < 20000)) begin
            @(negedge clk);
            t++;
            if ((prev === 1'b0) && (dht === 1'b1)) rises++;
            prev = dht;
        end
        check_eq("t5_reached_bit20", rises, 22);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst_busy", busy, 0);
        check_eq("t5_rst_cnt", frame_cnt, 0);
        check_eq("t5_rst_bus", dht, 1);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        watch_quiet(100, q_lows, q_busies);
        check_eq("t5_quiet_lows", q_lows, 0);
        host_pulse(120);
        read_frame(rd_data, rd_ack_lo, rd_ack_hi, rd_bad_w, rd_busy, rd_got);
        check_eq("t5_data", rd_data, 40'h23_00_19_00_3C);
        check_eq("t5_widths", rd_bad_w, 0);
        repeat (4) @(negedge clk);
        check_eq("t5_cnt", frame_cnt, 1);

        // 6: 256 back-to-back frames on the fast instance wrap the counter
        timeouts = 0;
        for (int f = 0; f < 256; f++) begin
            host_low_s = 1'b1;
            repeat (6) @(negedge clk);
            host_low_s = 1'b0;
            t = 0;
            while ((done_s !== 1'b1) && (t < 1000)) begin
                @(negedge clk);
                t++;
            end
            if (done_s !== 1'b1) timeouts++;
            repeat (4) @(negedge clk);
            if (f == 254) check_eq("t6_cnt_255", cnt_s, 255);
        end
        check_eq("t6_timeouts", timeouts, 0);
        check_eq("t6_cnt_wrap", cnt_s, 0);
        check_eq("t6_busy", busy_s, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
